// File: rtl/keypad_pkg.sv
// keypad_pkg: key map, pass-result codes and entry FSM states shared by the keypad entry block
package keypad_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  // index = row*4+col; layout 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };
  // pass results are {none, hex}; bit 4 set means no single key was seen
  localparam logic [4:0] KEY_NONE = 5'h10;
  typedef enum logic [2:0] {D_AH, D_AL, D_DH, D_DL, COMMIT} entry_state_t;
endpackage

// File: rtl/keypad_scan.sv
// keypad_scan: column scanner, single-key pass decoder and pass-level debouncer
//   clk_25M, rst_n (sync, active-low) | row_in[3:0] raw rows | col_out[3:0] active-low column drive
//   key_press: 1-cycle pulse on stable release->key transition | key_code[3:0]: hex of that key
module keypad_scan import keypad_pkg::*; #(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic       clk_25M,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_press,
  output logic [3:0] key_code
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  logic [3:0] row_s1, row_s2, acc_code, code_sel;
  logic [DW-1:0] div;
  logic [1:0] col, acc_n, col_n, tot, hit_row;
  logic [4:0] res, cand, stable;
  logic [CW-1:0] cnt, cnt_nx;
  logic sample, pass_end;
  assign col_out  = ~(4'b0001 << col);
  assign sample   = div == DW'(SCAN_DIV - 1);
  assign pass_end = sample && col == 2'd3;
  // closed-key count per pass saturates at 2: anything but exactly one key decodes as none
  always_comb begin
    col_n   = 2'd0;
    hit_row = 2'd0;
    for (int r = 0; r < NUM_ROWS; r++)
      if (!row_s2[r]) begin
        col_n   = col_n == 2'd0 ? 2'd1 : 2'd2;
        hit_row = 2'(r);
      end
    tot      = ({1'b0, acc_n} + {1'b0, col_n} > 3'd2) ? 2'd2 : acc_n + col_n;
    code_sel = col_n == 2'd1 ? KEY_MAP[{hit_row, col}] : acc_code;
    res      = tot == 2'd1 ? {1'b0, code_sel} : KEY_NONE;
    cnt_nx   = res != cand ? CW'(1) : cnt == CW'(DEBOUNCE_SCANS) ? cnt : cnt + 1'b1;
  end
  always_ff @(posedge clk_25M) begin
    row_s1    <= row_in;
    row_s2    <= row_s1;
    key_press <= 1'b0;
    if (!rst_n) begin
      row_s1   <= '1;
      row_s2   <= '1;
      div      <= '0;
      col      <= '0;
      acc_n    <= '0;
      acc_code <= '0;
      cand     <= KEY_NONE;
      stable   <= KEY_NONE;
      cnt      <= '0;
      key_code <= '0;
    end else begin
      div <= sample ? '0 : div + 1'b1;
      if (sample) begin
        col      <= col + 1'b1;
        acc_n    <= pass_end ? 2'd0 : tot;
        acc_code <= code_sel;
      end
      if (pass_end) begin
        cand <= res;
        cnt  <= cnt_nx;
        // only a stable none -> key change is a press; key -> key just retargets
        if (cnt_nx == CW'(DEBOUNCE_SCANS) && res != stable) begin
          stable    <= res;
          key_press <= stable == KEY_NONE && res != KEY_NONE;
          key_code  <= res[3:0];
        end
      end
    end
  end
endmodule

// File: rtl/keypad_conf_entry.sv
// keypad_conf_entry: collects four keypad hex digits into an SCCB register address/value pair
//   clk_25M, rst_n (sync, active-low) | row_in[3:0], col_out[3:0]: keypad matrix | clr: abort entry
//   conf_addr[7:0], conf_data[7:0]: committed pair | start: level, high from commit to next entry
//   entry_value[15:0]: {AH,AL,DH,DL} typed so far | entry_cnt[2:0]: digits in current entry
module keypad_conf_entry import keypad_pkg::*; #(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic        clk_25M,
  input  logic        rst_n,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  input  logic        clr,
  output logic [7:0]  conf_addr,
  output logic [7:0]  conf_data,
  output logic        start,
  output logic [15:0] entry_value,
  output logic [2:0]  entry_cnt
);
  entry_state_t state, state_nx;
  logic [15:0] value_nx;
  logic [7:0] addr_nx, data_nx;
  logic [2:0] cnt_nx;
  logic [3:0] key_code;
  logic start_nx, key_press;
  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_scan (
    .clk_25M(clk_25M), .rst_n(rst_n), .row_in(row_in), .col_out(col_out),
    .key_press(key_press), .key_code(key_code)
  );
  always_ff @(posedge clk_25M) begin
    if (!rst_n) begin
      state       <= D_AH;
      entry_value <= '0;
      entry_cnt   <= '0;
      conf_addr   <= '0;
      conf_data   <= '0;
      start       <= 1'b0;
    end else begin
      state       <= state_nx;
      entry_value <= value_nx;
      entry_cnt   <= cnt_nx;
      conf_addr   <= addr_nx;
      conf_data   <= data_nx;
      start       <= start_nx;
    end
  end
  // clr overrides everything, including a same-cycle digit or a pending commit
  always_comb begin
    state_nx = state;
    value_nx = entry_value;
    cnt_nx   = entry_cnt;
    addr_nx  = conf_addr;
    data_nx  = conf_data;
    start_nx = start;
    if (clr) begin
      state_nx = D_AH;
      value_nx = '0;
      cnt_nx   = '0;
      start_nx = 1'b0;
    end else
      case (state)
        D_AH: if (key_press) begin
          value_nx = {key_code, 12'h000};
          start_nx = 1'b0;
          cnt_nx   = 3'd1;
          state_nx = D_AL;
        end
        D_AL: if (key_press) begin
          value_nx[11:8] = key_code;
          cnt_nx         = 3'd2;
          state_nx       = D_DH;
        end
        D_DH: if (key_press) begin
          value_nx[7:4] = key_code;
          cnt_nx        = 3'd3;
          state_nx      = D_DL;
        end
        D_DL: if (key_press) begin
          value_nx[3:0] = key_code;
          cnt_nx        = 3'd0;
          state_nx      = COMMIT;
        end
        default: begin
          addr_nx  = entry_value[15:8];
          data_nx  = entry_value[7:0];
          start_nx = 1'b1;
          state_nx = D_AH;
        end
      endcase
  end
endmodule
